// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FP add issue/retire stage.
//   - op encoding (FP_OP_ADD / FP_OP_SUB)
//   - canonical quiet NaN
//   - output flag bit indices
//   - issue FSM state type
//   - binary64 classification helpers
package fpu_pkg;

  localparam logic FP_OP_ADD = 1'b0;
  localparam logic FP_OP_SUB = 1'b1;

  localparam logic [63:0] FP_CANON_NAN = 64'h7FF8000000000000;

  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_ZR = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } issue_state_t;

  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
  endfunction

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // Signalling NaN: NaN with the quiet bit (mantissa MSB) clear.
  function automatic logic is_snan(input logic [63:0] x);
    return is_nan(x) && !x[51];
  endfunction

  function automatic logic is_zero(input logic [63:0] x);
    return x[62:0] == 63'd0;
  endfunction

endpackage

// File: rtl/fp_op_fifo.sv
// fp_op_fifo: synchronous FIFO, parameterised width and power-of-two depth.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   i_push/i_wdata write request (ignored when full)
//   i_pop         read request (ignored when empty)
//   o_rdata       head entry, valid whenever o_empty is low
//   o_full/o_empty status, derived from registered pointers only
module fp_op_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // The head entry is needed in the same cycle as the pop decision, so the
  // read is asynchronous; storage is tiny (2..8 entries).
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_issue.sv
// fp_add_issue: issue/retire stage around an external combinational binary64
// adder. Requests are queued in fp_op_fifo, popped onto registered adder
// operands (b sign-flipped for FSUB), and after ADD_LAT cycles the adder
// result plus NV/OF/ZR flags are captured into a held output register.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             request handshake (in_ready = FIFO not full)
//   in_op, in_a, in_b, in_tag     request payload (op 0 = FADD, 1 = FSUB)
//   add_a, add_b / add_out        registered operands to / result from adder
//   out_valid/out_ready           result handshake
//   out_result, out_tag, out_flags captured result, tag, {NV, OF, ZR}
// Build option: FP_NAN_BYPASS_EN forces canonical NaN results for NaN inputs.
module fp_add_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int ADD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  input  logic [63:0]      add_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
);

  localparam int REQ_W = 1 + 64 + 64 + TAG_W;
  localparam logic [1:0] CNT_INIT = 2'(ADD_LAT - 1);

  logic [REQ_W-1:0] w_rd_data;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_req_op;
  logic [63:0]      w_req_a;
  logic [63:0]      w_req_b;
  logic [TAG_W-1:0] w_req_tag;
  logic [63:0]      w_b_pre;
  logic             w_a_inf;
  logic             w_b_inf;
  logic [63:0]      w_cap_result;
  logic [2:0]       w_cap_flags;

  issue_state_t     r_state;
  logic [1:0]       r_cnt;
  logic [63:0]      r_add_a;
  logic [63:0]      r_add_b;
  logic [TAG_W-1:0] r_tag;
  logic             r_inf_opp;   // both operands infinite with opposite signs
  logic             r_any_inf;
  logic             r_out_valid;
  logic [63:0]      r_out_result;
  logic [TAG_W-1:0] r_out_tag;
  logic [2:0]       r_out_flags;
`ifdef FP_NAN_BYPASS_EN
  logic             r_any_nan;
  logic             r_any_snan;
`endif

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  // Pop either from IDLE or straight out of DONE when the result is taken.
  assign w_pop    = !w_empty &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));

  fp_op_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({in_op, in_a, in_b, in_tag}),
    .i_pop   (w_pop),
    .o_rdata (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_req_op, w_req_a, w_req_b, w_req_tag} = w_rd_data;
  assign w_b_pre = (w_req_op == FP_OP_SUB) ? {~w_req_b[63], w_req_b[62:0]} : w_req_b;
  assign w_a_inf = is_inf(w_req_a);
  assign w_b_inf = is_inf(w_b_pre);

  // Result/flags presented to the output register on the capture edge.
  always_comb begin
    w_cap_result         = add_out;
    w_cap_flags          = 3'b000;
    w_cap_flags[FLAG_NV] = r_inf_opp;
    w_cap_flags[FLAG_OF] = is_inf(add_out) && !r_any_inf;
    w_cap_flags[FLAG_ZR] = is_zero(add_out);
`ifdef FP_NAN_BYPASS_EN
    if (r_any_nan) begin
      w_cap_result         = FP_CANON_NAN;
      w_cap_flags          = 3'b000;
      w_cap_flags[FLAG_NV] = r_any_snan;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 2'd0;
      r_add_a      <= 64'd0;
      r_add_b      <= 64'd0;
      r_tag        <= '0;
      r_inf_opp    <= 1'b0;
      r_any_inf    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= 64'd0;
      r_out_tag    <= '0;
      r_out_flags  <= 3'b000;
`ifdef FP_NAN_BYPASS_EN
      r_any_nan    <= 1'b0;
      r_any_snan   <= 1'b0;
`endif
    end else begin
      // Adder operands only move on pop edges, so they are stable for the
      // whole settle window.
      if (w_pop) begin
        r_add_a   <= w_req_a;
        r_add_b   <= w_b_pre;
        r_cnt     <= CNT_INIT;
        r_tag     <= w_req_tag;
        r_inf_opp <= w_a_inf && w_b_inf && (w_req_a[63] != w_b_pre[63]);
        r_any_inf <= w_a_inf || w_b_inf;
`ifdef FP_NAN_BYPASS_EN
        r_any_nan  <= is_nan(w_req_a) || is_nan(w_b_pre);
        r_any_snan <= is_snan(w_req_a) || is_snan(w_b_pre);
`endif
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (r_cnt == 2'd0) begin
            r_out_result <= w_cap_result;
            r_out_tag    <= r_tag;
            r_out_flags  <= w_cap_flags;
            r_out_valid  <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_empty ? ST_IDLE : ST_EXEC;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign out_flags  = r_out_flags;

endmodule

// File: tb/tb_fp_add_issue.sv
module tb_fp_add_issue;

  localparam int TAG_W      = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int ADD_LAT    = 1;
  localparam logic [63:0] CANON = 64'h7FF8000000000000;
  localparam logic [63:0] ONE   = 64'h3FF0000000000000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_op = 1'b0;
  logic [63:0]      in_a = 64'd0;
  logic [63:0]      in_b = 64'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [63:0]      add_a;
  logic [63:0]      add_b;
  logic [63:0]      add_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;

  typedef struct packed {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
  } exp_t;

  exp_t             q[$];
  logic [TAG_W-1:0] delivered[$];
  int               checks = 0;
  int               failures = 0;
  bit               seen = 0;
  exp_t             held;

  always #5 clk = ~clk;

  // Behavioural adder: host double arithmetic, NaN results made canonical.
  function automatic logic [63:0] fadd_ref(input logic [63:0] a, input logic [63:0] b);
    real r;
    logic [63:0] s;
    r = $bitstoreal(a) + $bitstoreal(b);
    s = $realtobits(r);
    if (s[62:52] == 11'h7FF && s[51:0] != 52'd0) s = CANON;
    return s;
  endfunction

  assign add_out = fadd_ref(add_a, add_b);

  function automatic bit m_inf(input logic [63:0] x);
    return x[62:52] == 11'h7FF && x[51:0] == 52'd0;
  endfunction
  function automatic bit m_nan(input logic [63:0] x);
    return x[62:52] == 11'h7FF && x[51:0] != 52'd0;
  endfunction

  // Expected response for one request, straight from the operation rules.
  function automatic exp_t model(input logic op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [63:0] bp;
    bp = op ? {~b[63], b[62:0]} : b;
    e.res = fadd_ref(a, bp);
    e.tag = tag;
    e.flags[2] = m_inf(a) && m_inf(bp) && (a[63] != bp[63]);
    e.flags[1] = m_inf(e.res) && !m_inf(a) && !m_inf(bp);
    e.flags[0] = (e.res[62:0] == 63'd0);
`ifdef FP_NAN_BYPASS_EN
    if (m_nan(a) || m_nan(bp)) begin
      e.res   = CANON;
      e.flags = {(m_nan(a) && !a[51]) || (m_nan(bp) && !bp[51]), 2'b00};
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard push: a request is accepted at the next edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_tag));
  end

  // Monitor: compare each new result once, then check it holds until taken.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!seen) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h required=none", out_result);
        end else begin
          check("result", out_result, q[0].res);
          check("tag", 64'(out_tag), 64'(q[0].tag));
          check("flags", 64'(out_flags), 64'(q[0].flags));
        end
        held = {out_result, out_tag, out_flags};
        seen = 1;
      end else begin
        check("held_result", out_result, held.res);
        check("held_tag_flags", 64'({out_tag, out_flags}), 64'({held.tag, held.flags}));
      end
      if (out_ready) begin
        $display("xfer tag=%0d result=%h flags=%b", out_tag, out_result, out_flags);
        delivered.push_back(out_tag);
        if (q.size() > 0) q.delete(0);
        seen = 0;
      end
    end
  end

  // Returns at posedge+1 with DUT idle and scoreboard drained.
  task automatic wait_idle();
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    seen = 0;
  endtask

  // Single request into an idle DUT: latency, adder operands and result.
  task automatic probe(input logic op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag, input logic [63:0] exp_res,
                       input logic [2:0] exp_flags);
    logic [63:0] bp;
    bp = op ? {~b[63], b[62:0]} : b;
    wait_idle();
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);  // t0: accepted
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_before_pop", 64'(out_valid), 64'd0);
    @(negedge clk);  // after t0+1: popped
    check("add_a", add_a, a);
    check("add_b", add_b, bp);
    check("lat_settle", 64'(out_valid), 64'd0);
    repeat (ADD_LAT - 1) begin
      @(negedge clk);
      check("lat_settle", 64'(out_valid), 64'd0);
    end
    @(negedge clk);  // after t0+1+ADD_LAT
    check("lat_capture", 64'(out_valid), 64'd1);
    check("probe_result", out_result, exp_res);
    check("probe_flags", 64'(out_flags), 64'(exp_flags));
  endtask

  function automatic logic [63:0] rnd_fp();
    logic [63:0] m;
    logic        s;
    m = {$urandom(), $urandom()};
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: return {s, 63'd0};
      1: return {s, 11'h7FF, 52'd0};
      2: return {s, 11'h7FE, 52'hFFFFFFFFFFFFF};
`ifdef FP_NAN_BYPASS_EN
      3: return {s, 11'h7FF, m[51:0] | 52'd1};
`endif
      default: return {s, 11'($urandom_range(1000, 1050)), m[51:0]};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t;
    bit took;
    logic [63:0] ra;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_add_a", add_a, 64'd0);
    check("rst_add_b", add_b, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag_flags", 64'({out_tag, out_flags}), 64'd0);

    // Directed arithmetic cases
    probe(1'b0, ONE, 64'h4000000000000000, 5'd1, 64'h4008000000000000, 3'b000);
    probe(1'b1, 64'h4008000000000000, ONE, 5'd2, 64'h4000000000000000, 3'b000);
    probe(1'b1, ONE, ONE, 5'd3, 64'd0, 3'b001);
    probe(1'b1, 64'h7FF0000000000000, 64'h7FF0000000000000, 5'd4, CANON, 3'b100);
    probe(1'b0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 5'd5, 64'h7FF0000000000000, 3'b010);
`ifdef FP_NAN_BYPASS_EN
    probe(1'b0, 64'h7FF4000000000000, ONE, 5'd6, CANON, 3'b100);
`endif

    // Backpressure: one held + FIFO_DEPTH queued, then in-order release
    wait_idle();
    delivered.delete();
    out_ready = 1'b0;
    acc = 0;
    t = 1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_op = 1'b0; in_a = $realtobits(real'(t)); in_b = ONE;
      in_tag = 5'(t);
      @(negedge clk);
      took = in_ready;
      if (took) acc++;
      if (c == 9) check("bp_in_ready_full", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      if (took) t++;
    end
    check("bp_accepts", 64'(acc), 64'(1 + FIFO_DEPTH));
    out_ready = 1'b1;
    for (int c = 0; c < 50 && in_valid; c++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) in_valid = 1'b0;
    end
    wait_idle();
    check("bp_delivered", 64'(delivered.size()), 64'd4);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      check("bp_order", 64'(delivered[i]), 64'(i + 1));

    // Reset while EXEC
    wait_idle();
    in_op = 1'b0; in_a = ONE; in_b = ONE; in_tag = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 do_reset();
    @(negedge clk);
    check("rexec_out_valid", 64'(out_valid), 64'd0);
    check("rexec_add_a", add_a, 64'd0);
    check("rexec_add_b", add_b, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rexec_in_ready", 64'(in_ready), 64'd1);
    repeat (4) @(negedge clk);
    check("rexec_no_stale", 64'(out_valid), 64'd0);

    // Reset while DONE
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_op = 1'b0; in_a = ONE; in_b = ONE; in_tag = 5'd10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) @(posedge clk);
    #1;
    check("rdone_reached", 64'(out_valid), 64'd1);
    do_reset();
    @(negedge clk);
    check("rdone_out_valid", 64'(out_valid), 64'd0);
    check("rdone_out_result", out_result, 64'd0);
    check("rdone_out_tag_flags", 64'({out_tag, out_flags}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rdone_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        ra     = rnd_fp();
        in_a   = ra;
        in_b   = ($urandom_range(0, 7) == 0) ? ra : rnd_fp();
        in_op  = 1'($urandom_range(0, 1));
        in_tag = 5'($urandom_range(0, 31));
        in_valid = 1'b1;
      end
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    wait_idle();
    check("final_in_ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  fp_add_issue #(
    .TAG_W      (TAG_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADD_LAT    (ADD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_out    (add_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

endmodule
